// File: rtl/wide_add_sequencer.sv
// Double-word add/subtract that reuses one nbits-wide Kogge-Stone adder over two passes (low, then high).
// Define WIDE_ADD_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.

module kogge_stone #(
  parameter int nbits = 32
) (
  input  logic [nbits-1:0] x,
  input  logic [nbits-1:0] y,
  input  logic             cin,
  output logic [nbits-1:0] prop_op,
  output logic [nbits-1:0] carry_network
);
  localparam int levels = $clog2(nbits);

  logic [nbits-1:0] g, p, g_nxt, p_nxt;

  // cin is folded into bit 0's generate, so carry_network[i] is the carry out of bit i.
  always_comb begin
    g_nxt = '0;
    p_nxt = '0;
    p = x ^ y;
    g = x & y;
    prop_op = p;
    g[0] = g[0] | (p[0] & cin);
    for (int l = 0; l < levels; l++) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = (1 << l); i < nbits; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_nxt[i] = p[i] & p[i - (1 << l)];
      end
      g = g_nxt;
      p = p_nxt;
    end
    carry_network = g;
  end
endmodule

module wide_add_sequencer #(
  parameter int nbits = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*nbits-1:0]   op_a,
  input  logic [2*nbits-1:0]   op_b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*nbits-1:0]   result,
  output logic                 cout,
  output logic                 ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [2*nbits-1:0] a_q, b_q;
  logic               sub_q;
  logic               carry_q;
  logic [nbits-1:0]   low_q;

  logic [nbits-1:0]   x, y, prop_op, carry_network, sum;
  logic               cin;
  logic [nbits:0]     c_vec;
  logic               accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    x   = a_q[nbits-1:0];
    y   = b_q[nbits-1:0];
    cin = sub_q;
    if (state == HIGH) begin
      x   = a_q[2*nbits-1:nbits];
      y   = b_q[2*nbits-1:nbits];
      cin = carry_q;
    end
    if (sub_q) y = ~y;
  end

  kogge_stone #(.nbits(nbits)) u_adder (
    .x             (x),
    .y             (y),
    .cin           (cin),
    .prop_op       (prop_op),
    .carry_network (carry_network)
  );

  assign c_vec = {carry_network, cin};
  assign sum   = prop_op ^ c_vec[nbits-1:0];

  // The low half waits in low_q so the visible result only moves when the whole word is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      low_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= sub;
            state <= LOW;
          end
        end
        LOW: begin
          low_q   <= sum;
          carry_q <= carry_network[nbits-1];
          state   <= HIGH;
        end
        HIGH: begin
          result <= {sum, low_q};
          cout   <= carry_network[nbits-1];
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (accept) begin
              a_q   <= op_a;
              b_q   <= op_b;
              sub_q <= sub;
              state <= LOW;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WIDE_ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == HIGH) begin
      ovf_q <= (x[nbits-1] == y[nbits-1]) && (sum[nbits-1] != x[nbits-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer (nbits=32); ovf expectations follow WIDE_ADD_OVF_EN.
module tb_wide_add_sequencer;
  localparam int W = 64;
`ifdef WIDE_ADD_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int total;
  int bad;

  wide_add_sequencer #(.nbits(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one request and hold it until the acceptance edge, then drop in_valid.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    sub      = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int edges;
    edges = 0;
    while (!out_valid && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'd2);
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] r, input logic c, input logic o);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_result"}, result, r);
    checkOutput({tag, "_cout"}, {63'd0, cout}, {63'd0, c});
    checkOutput({tag, "_ovf"}, {63'd0, ovf}, {63'd0, o & OVF_EN});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("drain_valid_low", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] r, input logic c, input logic o);
    applyStimulus(a, b, s);
    waitResult(tag);
    checkResult(tag, r, c, o);
    drain();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;

    #3;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_cout", {63'd0, cout}, 64'd0);
    checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("add_lowcarry", 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0);
    runOp("sub_borrow", 64'h0, 64'h1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
    runOp("add_wrap", 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    runOp("add_ovf", 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1);
    runOp("sub_small", 64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0);
    runOp("sub_ovf", 64'h80000000_00000000, 64'h1, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1);

    // Backpressure: result held in DONE while in_valid knocks with another request.
    applyStimulus(64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b0);
    waitResult("bp");
    checkResult("bp", 64'h23456789_ABCDF001, 1'b0, 1'b0);
    op_a     = 64'h00000001_80000000;
    op_b     = 64'h00000002_80000000;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_hold_result", result, 64'h23456789_ABCDF001);
      checkOutput("bp_hold_cout", {63'd0, cout}, 64'd0);
      checkOutput("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp_next_valid_low", {63'd0, out_valid}, 64'd0);
    waitResult("bp_next");
    checkResult("bp_next", 64'h00000004_00000000, 1'b0, 1'b0);
    drain();

    // Reset lands in the HIGH pass; nothing partial may surface.
    applyStimulus(64'h00000001_00000000, 64'h1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_cout", {63'd0, cout}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    checkOutput("midrst_hold_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runOp("after_rst", 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0);

    // Inputs wiggle during LOW and HIGH; the in-flight operation must not notice.
    applyStimulus(64'hAAAAAAAA_AAAAAAAA, 64'h55555555_55555556, 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_valid = ~in_valid;
      op_a     = {$urandom, $urandom};
      op_b     = {$urandom, $urandom};
      sub      = ~sub;
      @(negedge clk);
      checkOutput("flight_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("flight_out_valid", {63'd0, out_valid}, 64'd0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkResult("flight", 64'h0, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
